// File: rtl/button_conditioner.sv
// button_conditioner: synchronises, debounces and edge-detects the five raw
// calculator push-buttons, and keeps the Operation / Equals toggle states.
// Optional feature macro: BTN_AUTOREPEAT_EN (auto-repeat on Button1/Button2).
// Bit map: 0 = Button1, 1 = Button2, 2 = Equals, 3 = Reset button, 4 = Operation.
module button_conditioner #(
    parameter int DB_CYCLES     = 50000,
    parameter int REPEAT_DELAY  = 25000000,
    parameter int REPEAT_PERIOD = 10000000
) (
    input  logic       clk,
    input  logic       r,
    input  logic [4:0] btn_raw,
    output logic [4:0] press_pulse,
    output logic [4:0] held,
    output logic       op_mode,
    output logic       eq_mode,
    output logic       clr_pulse
);

    localparam int              CW      = $clog2(DB_CYCLES + 1);
    localparam logic [CW-1:0]   DB_LAST = CW'(DB_CYCLES - 1);

`ifdef BTN_AUTOREPEAT_EN
    localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW      = $clog2(REP_MAX + 1);
    localparam logic [RW-1:0] DELAY_LAST  = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] PERIOD_LAST = RW'(REPEAT_PERIOD - 1);
`endif

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        PRESSED = 2'd2,
        DISARM  = 2'd3
    } state_t;

    // A debounce window below two samples cannot reject anything.
    if (DB_CYCLES < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_cfg
        $error("button_conditioner: DB_CYCLES must be >= 2 and repeat timings >= 1");
    end

    logic [4:0] sync1_reg;
    logic [4:0] sync2_reg;
    logic [4:0] pulse_next;
    logic [4:0] held_next;
    logic [4:0] press_pulse_reg;
    logic [4:0] held_reg;
    logic       op_mode_reg;
    logic       op_mode_next;
    logic       eq_mode_reg;
    logic       eq_mode_next;
    logic       clr_pulse_reg;

    // Two-flop synchroniser for all five asynchronous button levels.
    always_ff @(posedge clk) begin
        if (r) begin
            sync1_reg <= '0;
            sync2_reg <= '0;
        end else begin
            sync1_reg <= btn_raw;
            sync2_reg <= sync1_reg;
        end
    end

    genvar gi;
    for (gi = 0; gi < 5; gi++) begin : g_bit
        state_t        state_reg;
        state_t        state_next;
        logic [CW-1:0] cnt_reg;
        logic [CW-1:0] cnt_next;
        logic          s;
        logic          deb_pulse;
        logic          rep_fire;

        assign s = sync2_reg[gi];

        // Debounce state and run-length counter registers.
        always_ff @(posedge clk) begin
            if (r) begin
                state_reg <= IDLE;
                cnt_reg   <= '0;
            end else begin
                state_reg <= state_next;
                cnt_reg   <= cnt_next;
            end
        end

        // Next state: a level change is accepted after DB_CYCLES equal samples.
        always_comb begin
            state_next = state_reg;
            cnt_next   = cnt_reg;
            deb_pulse  = 1'b0;
            case (state_reg)
                IDLE: begin
                    if (s) begin
                        state_next = ARM;
                        cnt_next   = CW'(1);
                    end
                end
                ARM: begin
                    if (!s) begin
                        state_next = IDLE;
                        cnt_next   = '0;
                    end else if (cnt_reg >= DB_LAST) begin
                        state_next = PRESSED;
                        cnt_next   = '0;
                        deb_pulse  = 1'b1;
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end
                PRESSED: begin
                    if (!s) begin
                        state_next = DISARM;
                        cnt_next   = CW'(1);
                    end
                end
                DISARM: begin
                    if (s) begin
                        state_next = PRESSED;
                        cnt_next   = '0;
                    end else if (cnt_reg >= DB_LAST) begin
                        state_next = IDLE;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end
                default: begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end
            endcase
        end

`ifdef BTN_AUTOREPEAT_EN
        if (gi < 2) begin : g_rep
            logic [RW-1:0] rep_cnt_reg;
            logic [RW-1:0] rep_cnt_next;
            logic          rep_late_reg;
            logic          rep_late_next;
            logic          rep_hit;

            // Repeat timer registers; cleared by reset.
            always_ff @(posedge clk) begin
                if (r) begin
                    rep_cnt_reg  <= '0;
                    rep_late_reg <= 1'b0;
                end else begin
                    rep_cnt_reg  <= rep_cnt_next;
                    rep_late_reg <= rep_late_next;
                end
            end

            // First repeat after the long delay, then at the shorter period;
            // leaving the held states wins over a repeat due on the same edge.
            always_comb begin
                rep_cnt_next  = rep_cnt_reg;
                rep_late_next = rep_late_reg;
                rep_hit       = 1'b0;
                if (deb_pulse || state_next == IDLE || state_next == ARM) begin
                    rep_cnt_next  = '0;
                    rep_late_next = 1'b0;
                end else if (rep_cnt_reg == (rep_late_reg ? PERIOD_LAST : DELAY_LAST)) begin
                    rep_hit       = 1'b1;
                    rep_cnt_next  = '0;
                    rep_late_next = 1'b1;
                end else if (rep_cnt_reg != '1) begin
                    rep_cnt_next = rep_cnt_reg + 1'b1;
                end
            end

            assign rep_fire = rep_hit;
        end else begin : g_norep
            assign rep_fire = 1'b0;
        end
`else
        assign rep_fire = 1'b0;
`endif

        assign held_next[gi]  = (state_next == PRESSED) || (state_next == DISARM);
        assign pulse_next[gi] = deb_pulse | rep_fire;
    end

    // Toggle controls follow the pulses on the same edge; Reset-button clear wins.
    always_comb begin
        op_mode_next = op_mode_reg ^ pulse_next[4];
        eq_mode_next = eq_mode_reg;
        if (pulse_next[3]) begin
            eq_mode_next = 1'b0;
        end else if (pulse_next[2]) begin
            eq_mode_next = ~eq_mode_reg;
        end
    end

    // Output registers, so nothing downstream sees a combinational path from the pins.
    always_ff @(posedge clk) begin
        if (r) begin
            press_pulse_reg <= '0;
            held_reg        <= '0;
            op_mode_reg     <= 1'b0;
            eq_mode_reg     <= 1'b0;
            clr_pulse_reg   <= 1'b0;
        end else begin
            press_pulse_reg <= pulse_next;
            held_reg        <= held_next;
            op_mode_reg     <= op_mode_next;
            eq_mode_reg     <= eq_mode_next;
            clr_pulse_reg   <= pulse_next[3];
        end
    end

    assign press_pulse = press_pulse_reg;
    assign held        = held_reg;
    assign op_mode     = op_mode_reg;
    assign eq_mode     = eq_mode_reg;
    assign clr_pulse   = clr_pulse_reg;

endmodule
